// File: rtl/monster_score_hud.sv
// Samples the monster stomp count, converts it to three BCD digits with a serial
// double-dabble engine, and drives a frame-timed stomp popup. Optional macro: MONSTER_HUD_BLANK_EN.
module monster_score_hud #(
  parameter int CNT_W        = 8,
  parameter int POPUP_FRAMES = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] monster_num,
  input  logic             frame_tick,
  output logic [3:0]       bcd_hundreds,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             digits_valid,
  output logic             busy,
  output logic             popup_on,
  output logic [7:0]       popup_y_off,
  output logic [2:0]       digit_blank,
  output logic [1:0]       dbg_state
);

  localparam int SR_W = CNT_W + 12;
  localparam int RF_W = $clog2(POPUP_FRAMES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  snap_q, snap_d;
  logic [SR_W-1:0]   sr_q, sr_d, sr_adj;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [3:0]        hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
  logic              valid_q, valid_d, busy_q, busy_d;
  logic              pop_on_q, pop_on_d;
  logic [7:0]        y_off_q, y_off_d;
  logic [RF_W-1:0]   rem_q, rem_d;
  logic              capture;
`ifdef MONSTER_HUD_BLANK_EN
  logic [2:0]        blank_q, blank_d;
`endif

  // Add-3 correction on each BCD nibble before the shift.
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < 3; i++) begin
      if (sr_q[CNT_W+4*i +: 4] >= 4'd5) begin
        sr_adj[CNT_W+4*i +: 4] = sr_q[CNT_W+4*i +: 4] + 4'd3;
      end
    end
  end

  assign capture = (state_q == IDLE) && (monster_num != snap_q);

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    hund_d    = hund_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    pop_on_d  = pop_on_q;
    y_off_d   = y_off_q;
    rem_d     = rem_q;
`ifdef MONSTER_HUD_BLANK_EN
    blank_d   = blank_q;
`endif
    case (state_q)
      IDLE: begin
        if (capture) begin
          snap_d    = monster_num;
          sr_d      = {12'b0, monster_num};
          bit_cnt_d = 4'(CNT_W);
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        sr_d      = sr_adj << 1;
        bit_cnt_d = bit_cnt_q - 4'd1;
        if (bit_cnt_q == 4'd1) state_d = DONE;
      end
      DONE: begin
        hund_d  = sr_q[CNT_W+8 +: 4];
        tens_d  = sr_q[CNT_W+4 +: 4];
        ones_d  = sr_q[CNT_W   +: 4];
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
`ifdef MONSTER_HUD_BLANK_EN
        blank_d = {(hund_d == 4'd0), (hund_d == 4'd0) && (tens_d == 4'd0), 1'b0};
`endif
      end
      default: state_d = IDLE;
    endcase

    // A capture decides the popup outright; a same-cycle frame tick is dropped.
    if (capture) begin
      y_off_d = 8'd0;
      if (monster_num > snap_q) begin
        pop_on_d = 1'b1;
        rem_d    = RF_W'(POPUP_FRAMES);
      end else begin
        pop_on_d = 1'b0;
      end
    end else if (frame_tick && pop_on_q) begin
      rem_d   = rem_q - RF_W'(1);
      y_off_d = y_off_q + 8'd1;
      if (rem_q == RF_W'(1)) pop_on_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      hund_q    <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      pop_on_q  <= 1'b0;
      y_off_q   <= '0;
      rem_q     <= '0;
`ifdef MONSTER_HUD_BLANK_EN
      blank_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      hund_q    <= hund_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      pop_on_q  <= pop_on_d;
      y_off_q   <= y_off_d;
      rem_q     <= rem_d;
`ifdef MONSTER_HUD_BLANK_EN
      blank_q   <= blank_d;
`endif
    end
  end

  assign bcd_hundreds = hund_q;
  assign bcd_tens     = tens_q;
  assign bcd_ones     = ones_q;
  assign digits_valid = valid_q;
  assign busy         = busy_q;
  assign popup_on     = pop_on_q;
  assign popup_y_off  = y_off_q;
  assign dbg_state    = state_q;
`ifdef MONSTER_HUD_BLANK_EN
  assign digit_blank  = blank_q;
`else
  assign digit_blank  = 3'b000;
`endif

endmodule

// File: tb/tb_monster_score_hud.sv
// Bench for monster_score_hud: digit table, directed popup/abort sequences, and
// randomized traffic checked every cycle against an arithmetic reference model.
module tb_monster_score_hud;

  localparam int CNT_W        = 8;
  localparam int POPUP_FRAMES = 30;

  // Valid/ready is not used here: monster_num is a level, frame_tick and digits_valid are 1-clk pulses.
  logic             clk = 1'b0;
  logic             reset;
  logic [CNT_W-1:0] monster_num;
  logic             frame_tick;
  logic [3:0]       bcd_hundreds, bcd_tens, bcd_ones;
  logic             digits_valid, busy, popup_on;
  logic [7:0]       popup_y_off;
  logic [2:0]       digit_blank;
  logic [1:0]       dbg_state;

  int checks   = 0;
  int failures = 0;

  monster_score_hud #(.CNT_W(CNT_W), .POPUP_FRAMES(POPUP_FRAMES)) dut (
    .clk(clk), .reset(reset), .monster_num(monster_num), .frame_tick(frame_tick),
    .bcd_hundreds(bcd_hundreds), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .digits_valid(digits_valid), .busy(busy), .popup_on(popup_on),
    .popup_y_off(popup_y_off), .digit_blank(digit_blank), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] blank_of(input int v);
`ifdef MONSTER_HUD_BLANK_EN
    return {(v / 100) == 0, (v / 10) == 0, 1'b0};
`else
    return 3'b000;
`endif
  endfunction

  // ---------------- reference model ----------------
  // Conversion is modelled as "value appears CNT_W+1 edges after capture"; digits by division.
  int m_snap = 0, m_cnt = 0, m_pend = 0;
  int m_h = 0, m_t = 0, m_o = 0, m_valid = 0;
  int m_on = 0, m_rem = 0, m_y = 0;
  logic [2:0] m_blank = 3'b000;

  task automatic model_reset();
    m_snap = 0; m_cnt = 0; m_pend = 0;
    m_h = 0; m_t = 0; m_o = 0; m_valid = 0;
    m_on = 0; m_rem = 0; m_y = 0; m_blank = 3'b000;
  endtask

  task automatic model_step();
    int num;
    bit cap;
    num = int'(monster_num);
    cap = 1'b0;
    m_valid = 0;
    if (m_cnt == 0) begin
      if (num != m_snap) begin
        cap = 1'b1;
        m_y = 0;
        if (num > m_snap) begin m_on = 1; m_rem = POPUP_FRAMES; end
        else m_on = 0;
        m_snap = num; m_pend = num; m_cnt = CNT_W + 1;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_h = m_pend / 100; m_t = (m_pend / 10) % 10; m_o = m_pend % 10;
        m_valid = 1;
        m_blank = blank_of(m_pend);
      end
    end
    if (!cap && frame_tick && m_on != 0) begin
      m_rem--; m_y++;
      if (m_rem == 0) m_on = 0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // ---------------- scoreboard: every cycle vs model ----------------
  initial begin
    forever begin
      @(posedge clk);
      #3;
      check("sb_hundreds", 32'(bcd_hundreds), 32'(m_h));
      check("sb_tens",     32'(bcd_tens),     32'(m_t));
      check("sb_ones",     32'(bcd_ones),     32'(m_o));
      check("sb_valid",    32'(digits_valid), 32'(m_valid));
      check("sb_busy",     32'(busy),         32'(m_cnt != 0));
      check("sb_popup_on", 32'(popup_on),     32'(m_on));
      check("sb_y_off",    32'(popup_y_off),  32'(m_y));
      check("sb_blank",    32'(digit_blank),  32'(m_blank));
    end
  end

  // ---------------- driver tasks ----------------
  // Waits for digits_valid; edges counts posedges including the sampling edge.
  task automatic wait_valid(output int edges, output bit ok);
    edges = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #3;
      edges++;
      if (digits_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_num(input int v);
    @(negedge clk);
    monster_num = CNT_W'(v);
  endtask

  task automatic convert(input int v);
    int e;
    bit ok;
    set_num(v);
    wait_valid(e, ok);
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  // ---------------- digit table ----------------
  typedef struct {
    int         num;
    logic [3:0] h, t, o;
    logic [2:0] blank;
  } vec_t;

  vec_t vecs[8];
  logic [11:0] exp_q[$];

  initial begin
    int e, pulses;
    bit ok;
    logic [11:0] got;

    vecs[0] = '{num: 9,   h: 4'd0, t: 4'd0, o: 4'd9, blank: 3'b110};
    vecs[1] = '{num: 255, h: 4'd2, t: 4'd5, o: 4'd5, blank: 3'b000};
    vecs[2] = '{num: 0,   h: 4'd0, t: 4'd0, o: 4'd0, blank: 3'b110};
    vecs[3] = '{num: 100, h: 4'd1, t: 4'd0, o: 4'd0, blank: 3'b000};
    vecs[4] = '{num: 42,  h: 4'd0, t: 4'd4, o: 4'd2, blank: 3'b100};
    vecs[5] = '{num: 199, h: 4'd1, t: 4'd9, o: 4'd9, blank: 3'b000};
    vecs[6] = '{num: 7,   h: 4'd0, t: 4'd0, o: 4'd7, blank: 3'b110};
    vecs[7] = '{num: 10,  h: 4'd0, t: 4'd1, o: 4'd0, blank: 3'b100};

    reset = 1'b1;
    monster_num = '0;
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_digits", {20'd0, bcd_hundreds, bcd_tens, bcd_ones}, 32'd0);
    check("rst_flags",  {29'd0, digits_valid, busy, popup_on}, 32'd0);
    check("rst_y_off",  32'(popup_y_off), 32'd0);
    check("rst_blank",  32'(digit_blank), 32'd0);
    check("rst_state",  32'(dbg_state), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      set_num(vecs[i].num);
      wait_valid(e, ok);
      check("tbl_latency", 32'(e - 1), 32'(CNT_W + 1));
      check("tbl_digits", {20'd0, bcd_hundreds, bcd_tens, bcd_ones},
            {20'd0, vecs[i].h, vecs[i].t, vecs[i].o});
`ifdef MONSTER_HUD_BLANK_EN
      check("tbl_blank", 32'(digit_blank), 32'(vecs[i].blank));
`else
      check("tbl_blank", 32'(digit_blank), 32'd0);
`endif
    end

    // Reset in the middle of converting 200, then reconvert with input held.
    set_num(200);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_digits", {20'd0, bcd_hundreds, bcd_tens, bcd_ones}, 32'd0);
    check("abort_flags",  {29'd0, digits_valid, busy, popup_on}, 32'd0);
    check("abort_y_off",  32'(popup_y_off), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_valid(e, ok);
    check("abort_latency", 32'(e - 1), 32'(CNT_W + 1));
    check("abort_digits2", {20'd0, bcd_hundreds, bcd_tens, bcd_ones}, 32'h200);

    // 0 -> 1 popup lifetime.
    convert(0);
    convert(1);
    check("pop_digits", {20'd0, bcd_hundreds, bcd_tens, bcd_ones}, 32'h001);
    check("pop_on", 32'(popup_on), 32'd1);
    repeat (POPUP_FRAMES - 1) tick();
    check("pop_on_29", 32'(popup_on), 32'd1);
    tick();
    check("pop_off_30", 32'(popup_on), 32'd0);
    check("pop_y_30", 32'(popup_y_off), 32'(POPUP_FRAMES));

    // Input change while busy is picked up by a second conversion.
    convert(0);
    set_num(1);
    exp_q.push_back(12'h001);
    exp_q.push_back(12'h002);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 3) monster_num = CNT_W'(2);
      if (digits_valid) begin
        pulses++;
        got = {bcd_hundreds, bcd_tens, bcd_ones};
        if (exp_q.size() > 0) check("busy_seq_digits", 32'(got), 32'(exp_q.pop_front()));
        else check("busy_seq_extra", 32'(got), 32'hfff);
      end
    end
    check("busy_seq_pulses", 32'(pulses), 32'd2);
    check("busy_seq_left", 32'(exp_q.size()), 32'd0);

    // Retrigger coinciding with a frame tick reloads the popup.
    convert(5);
    repeat (20) tick();
    check("retrig_pre_y", 32'(popup_y_off), 32'd20);
    @(negedge clk);
    monster_num = CNT_W'(6);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check("retrig_on", 32'(popup_on), 32'd1);
    check("retrig_y", 32'(popup_y_off), 32'd0);
    repeat (POPUP_FRAMES - 1) tick();
    check("retrig_on_29", 32'(popup_on), 32'd1);
    tick();
    check("retrig_off_30", 32'(popup_on), 32'd0);

    // Level restart clears the popup on the capture cycle.
    convert(7);
    check("restart_pre_on", 32'(popup_on), 32'd1);
    set_num(0);
    @(negedge clk);
    check("restart_on", 32'(popup_on), 32'd0);
    check("restart_y", 32'(popup_y_off), 32'd0);
    wait_valid(e, ok);
    check("restart_digits", {20'd0, bcd_hundreds, bcd_tens, bcd_ones}, 32'd0);

    // Randomized traffic; the scoreboard compares every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          monster_num = CNT_W'($urandom_range(0, (1 << CNT_W) - 1));
        end else begin
          int v;
          v = int'(monster_num) + int'($urandom_range(0, 4)) - 1;
          if (v < 0) v = 0;
          if (v > (1 << CNT_W) - 1) v = (1 << CNT_W) - 1;
          monster_num = CNT_W'(v);
        end
      end
      frame_tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    frame_tick = 1'b0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
